// File: rtl/inst_seq.sv
// Instruction sequencer: the host loads a short program into a small
// instruction memory, which is then replayed for loop_cnt passes, one issue slot per clock.
module inst_seq #(
  parameter int INST_WIDTH = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_clr,
  input  logic                  inst_in_v,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic                  start,
  input  logic [LOOP_WIDTH-1:0] loop_cnt,
  output logic                  inst_v,
  output logic [2:0]            opcode,
  output logic                  busy,
  output logic                  done,
  output logic                  full
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LEN_FULL = (ADDR_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);

  state_t state, next_state;

  logic [INST_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;   // also the program length
  logic [ADDR_WIDTH-1:0] pc;
  logic [3:0]            rep;
  logic [LOOP_WIDTH-1:0] pass;
  logic [LOOP_WIDTH-1:0] loops;
  logic                  done_pend;

  logic do_clr, do_wr, accept, launch, rep_end, pc_end, pass_end, last_slot;

  assign full = (wr_ptr == LEN_FULL);
  assign busy = (state == RUN);

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    do_clr     = 1'b0;
    do_wr      = 1'b0;
    accept     = 1'b0;
    launch     = 1'b0;
    rep_end    = (rep == imem[pc][3:0]);
    pc_end     = ({1'b0, pc} == (wr_ptr - LEN_ONE));
    pass_end   = (pass == (loops - LOOP_ONE));
    last_slot  = 1'b0;
    case (state)
      IDLE: begin
        if (prog_clr) begin
          do_clr = 1'b1;
        end else if (start) begin
          accept = 1'b1;
          if (loop_cnt != '0 && wr_ptr != '0) begin
            launch     = 1'b1;
            next_state = RUN;
          end
        end else if (inst_in_v && !full) begin
          do_wr = 1'b1;
        end
      end
      RUN: begin
        last_slot = rep_end && pc_end && pass_end;
        if (last_slot) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      pc        <= '0;
      rep       <= '0;
      pass      <= '0;
      loops     <= '0;
      inst_v    <= 1'b0;
      opcode    <= 3'b000;
      done      <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      done      <= done_pend;
      done_pend <= 1'b0;
      inst_v    <= 1'b0;
      opcode    <= 3'b000;
      if (do_clr) wr_ptr <= '0;
      if (do_wr)  wr_ptr <= wr_ptr + LEN_ONE;
      if (launch) begin
        loops <= loop_cnt;
        pc    <= '0;
        rep   <= '0;
        pass  <= '0;
      end else if (accept) begin
        done_pend <= 1'b1;
      end
      if (state == RUN) begin
        inst_v <= 1'b1;
        opcode <= imem[pc][INST_WIDTH-1 -: 3];
        if (!rep_end) begin
          rep <= rep + 4'd1;
        end else begin
          rep <= '0;
          if (pc_end) begin
            pc   <= '0;
            pass <= pass + LOOP_ONE;
          end else begin
            pc <= pc + ADDR_WIDTH'(1);
          end
        end
        if (last_slot) done_pend <= 1'b1;
      end
    end
  end

  // NOTE: the instruction memory has no reset; stale entries are unreachable
  // because wr_ptr, the program length, is reset to zero.
  always_ff @(posedge clk) begin
    if (do_wr) imem[wr_ptr[ADDR_WIDTH-1:0]] <= inst_in;
  end

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq: directed scenarios plus random programs
// compared against a queue-based model of the expected issue stream.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_clr = 1'b0;
  logic        inst_in_v = 1'b0;
  logic [31:0] inst_in = '0;
  logic        start = 1'b0;
  logic [7:0]  loop_cnt = '0;
  logic        inst_v;
  logic [2:0]  opcode;
  logic        busy;
  logic        done;
  logic        full;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog[$];

  inst_seq dut (
    .clk(clk), .rst(rst), .prog_clr(prog_clr), .inst_in_v(inst_in_v),
    .inst_in(inst_in), .start(start), .loop_cnt(loop_cnt),
    .inst_v(inst_v), .opcode(opcode), .busy(busy), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] r);
    logic [24:0] mid;
    mid = 25'($urandom);
    return {op, mid, r};
  endfunction

  task automatic write_inst(input logic [31:0] w);
    inst_in_v = 1'b1;
    inst_in   = w;
    tick();
    inst_in_v = 1'b0;
    if (prog.size() < 16) prog.push_back(w);
  endtask

  task automatic clear_prog();
    prog_clr = 1'b1;
    tick();
    prog_clr = 1'b0;
    prog.delete();
    check("full_after_clr", full, 1'b0);
  endtask

  // Expected stream: loops passes over the program, each entry issued rep+1 times.
  task automatic run(input int loops, input bit wr_too);
    logic [2:0] exp_q[$];
    int n;
    exp_q = {};
    for (int p = 0; p < loops; p++)
      for (int i = 0; i < prog.size(); i++)
        for (int r = 0; r <= int'(prog[i][3:0]); r++)
          exp_q.push_back(prog[i][31:29]);
    n = exp_q.size();
    start    = 1'b1;
    loop_cnt = 8'(loops);
    if (wr_too) begin
      inst_in_v = 1'b1;
      inst_in   = $urandom;
    end
    tick();
    start     = 1'b0;
    inst_in_v = 1'b0;
    check("busy_at_start", busy, n != 0);
    check("inst_v_at_start", inst_v, 1'b0);
    check("done_at_start", done, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick();
      check("issue_valid", inst_v, 1'b1);
      check("issue_opcode", opcode, exp_q[i]);
      check("issue_busy", busy, i < n - 1);
      check("issue_done", done, 1'b0);
    end
    tick();
    check("end_inst_v", inst_v, 1'b0);
    check("end_opcode", opcode, 3'b000);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    tick();
    check("done_width", done, 1'b0);
    check("idle_inst_v", inst_v, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_inst_v", inst_v, 1'b0);
    check("rst_opcode", opcode, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_full", full, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ADD, MUL, SUB once
    write_inst(mk(3'b001, 4'd0));
    write_inst(mk(3'b100, 4'd0));
    write_inst(mk(3'b010, 4'd0));
    run(1, 1'b0);

    // MULADD x3, MAX x1, three passes; then rerun the retained program
    clear_prog();
    write_inst(mk(3'b101, 4'd2));
    write_inst(mk(3'b111, 4'd0));
    run(3, 1'b0);
    run(1, 1'b0);

    // Fill to capacity; the 17th write is dropped
    clear_prog();
    for (int i = 0; i < 17; i++) begin
      write_inst(mk(3'($urandom), 4'd0));
      if (i == 14) check("full_at_15", full, 1'b0);
      if (i == 15) check("full_at_16", full, 1'b1);
      if (i == 16) check("full_at_17", full, 1'b1);
    end
    run(1, 1'b0);

    // Empty program and zero pass count
    clear_prog();
    run(1, 1'b0);
    write_inst(mk(3'b011, 4'd1));
    run(0, 1'b0);

    // start with prog_clr: clear wins, no run, no done
    start    = 1'b1;
    prog_clr = 1'b1;
    loop_cnt = 8'd2;
    tick();
    start    = 1'b0;
    prog_clr = 1'b0;
    prog.delete();
    check("clr_start_busy", busy, 1'b0);
    check("clr_start_full", full, 1'b0);
    tick();
    check("clr_start_done", done, 1'b0);
    check("clr_start_inst_v", inst_v, 1'b0);
    run(1, 1'b0);

    // start with inst_in_v: write dropped, old length used twice
    write_inst(mk(3'b110, 4'd1));
    write_inst(mk(3'b001, 4'd0));
    run(2, 1'b1);
    run(1, 1'b0);

    // Random programs
    for (int t = 0; t < 6; t++) begin
      int len;
      clear_prog();
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++)
        write_inst(mk(3'($urandom), 4'($urandom_range(0, 3))));
      run(int'($urandom_range(1, 3)), 1'b0);
    end

    // Reset in the middle of a 4-pass run
    clear_prog();
    write_inst(mk(3'b101, 4'd1));
    write_inst(mk(3'b100, 4'd1));
    start    = 1'b1;
    loop_cnt = 8'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_inst_v", inst_v, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_inst_v", inst_v, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_opcode", opcode, 3'b000);
    tick();
    rst = 1'b0;
    prog.delete();
    check("post_rst_full", full, 1'b0);
    tick();
    check("post_rst_done", done, 1'b0);
    check("post_rst_inst_v", inst_v, 1'b0);
    run(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
